// File: rtl/inst_fetch_buf_pkg.sv
// Shared widths, constants and FSM state encoding for the instruction-fetch buffer.
// The prefetch feature is enabled by the macro INST_FETCH_PREFETCH_EN.
package inst_fetch_buf_pkg;

  localparam int INST_ADDR_W = 32;
  localparam int INST_DATA_W = 32;
  localparam int ALIGN_W     = 2;

  localparam logic [INST_DATA_W-1:0] ZERO_WORD = '0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_PREF = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/inst_fetch_buf_if.sv
// Instruction-memory req/ack bus; the fetch buffer is the master, the memory the slave.
interface inst_fetch_buf_if
  import inst_fetch_buf_pkg::*;
#(
  parameter int ADDR_W = INST_ADDR_W,
  parameter int DATA_W = INST_DATA_W
) ();

  logic              mem_req_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic              mem_ack_i;
  logic [DATA_W-1:0] mem_rdata_i;

  modport master (output mem_req_o, mem_addr_o, input mem_ack_i, mem_rdata_i);
  modport slave  (input mem_req_o, mem_addr_o, output mem_ack_i, mem_rdata_i);

endinterface

// File: rtl/inst_fetch_buf_entry.sv
// One buffer entry: valid/tag/data registers with clear and write, plus a combinational tag match.
module fetch_buf_entry #(
  parameter int TAG_W  = 30,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              we,
  input  logic [TAG_W-1:0]  wtag,
  input  logic [DATA_W-1:0] wdata,
  input  logic [TAG_W-1:0]  lookup_tag,
  output logic              match,
  output logic [DATA_W-1:0] data
);

  logic             valid;
  logic [TAG_W-1:0] tag;

  // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of block order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: tag/data are reset as well as valid so the match and data paths never carry X.
      valid <= 1'b0;
      tag   <= '0;
      data  <= '0;
    end else begin
      if (clr) begin
        valid <= 1'b0;
      end else if (we) begin
        valid <= 1'b1;
      end
      if (we) begin
        tag  <= wtag;
        data <= wdata;
      end
    end
  end

  assign match = valid && (tag == lookup_tag);

endmodule

// File: rtl/inst_fetch_buf.sv
// Instruction-fetch buffer: same-cycle hits, stall + memory fetch on a miss, sticky timeout flag.
// Defining INST_FETCH_PREFETCH_EN adds a second entry that streams the next sequential word.
module inst_fetch_buf
  import inst_fetch_buf_pkg::*;
#(
  parameter int ADDR_W  = INST_ADDR_W,
  parameter int DATA_W  = INST_DATA_W,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_ce_i,
  input  logic [ADDR_W-1:0] cpu_addr_i,
  output logic [DATA_W-1:0] cpu_inst_o,
  output logic              stall_req_o,
  input  logic              flush_i,
  inst_fetch_buf_if.master  bus,
  output logic              err_o
);

  localparam int TAG_W = ADDR_W - ALIGN_W;
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  fetch_state_e     state_q, state_d;
  logic [TAG_W-1:0] req_tag_q, req_tag_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;

  logic [TAG_W-1:0]   cpu_tag;
  logic [ALIGN_W-1:0] unused_byte_sel;

  logic              match0, match1, hit0, hit1;
  logic [DATA_W-1:0] data0, data1;
  logic              fill0;
  logic [TAG_W-1:0]  wtag0;
  logic [DATA_W-1:0] wdata0;

  assign cpu_tag         = cpu_addr_i[ADDR_W-1:ALIGN_W];
  assign unused_byte_sel = cpu_addr_i[ALIGN_W-1:0];

  fetch_buf_entry #(.TAG_W(TAG_W), .DATA_W(DATA_W)) u_entry0 (
    .clk        (clk),
    .rst        (rst),
    .clr        (flush_i),
    .we         (fill0),
    .wtag       (wtag0),
    .wdata      (wdata0),
    .lookup_tag (cpu_tag),
    .match      (match0),
    .data       (data0)
  );

`ifdef INST_FETCH_PREFETCH_EN
  logic fill1;

  fetch_buf_entry #(.TAG_W(TAG_W), .DATA_W(DATA_W)) u_entry1 (
    .clk        (clk),
    .rst        (rst),
    .clr        (flush_i),
    .we         (fill1),
    .wtag       (req_tag_q),
    .wdata      (bus.mem_rdata_i),
    .lookup_tag (cpu_tag),
    .match      (match1),
    .data       (data1)
  );
`else
  assign match1 = 1'b0;
  assign data1  = '0;
`endif

  // Entry 0 wins when both hold the same word; hit1 means "only entry 1 holds it".
  assign hit0        = cpu_ce_i && match0;
  assign hit1        = cpu_ce_i && match1 && !match0;
  assign stall_req_o = cpu_ce_i && !(match0 || match1);

  always_comb begin
    cpu_inst_o = DATA_W'(ZERO_WORD);
    if (hit0) begin
      cpu_inst_o = data0;
    end else if (hit1) begin
      cpu_inst_o = data1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      req_tag_q <= '0;
      cnt_q     <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      req_tag_q <= req_tag_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
    end
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_d   = state_q;
    req_tag_d = req_tag_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    fill0     = 1'b0;
    wtag0     = req_tag_q;
    wdata0    = bus.mem_rdata_i;
`ifdef INST_FETCH_PREFETCH_EN
    fill1     = 1'b0;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (stall_req_o) begin
          req_tag_d = cpu_tag;
          cnt_d     = '0;
          state_d   = ST_BUSY;
        end
`ifdef INST_FETCH_PREFETCH_EN
        else if (hit1) begin
          // Streaming: promote the prefetched word and fetch the one after it.
          fill0     = 1'b1;
          wtag0     = cpu_tag;
          wdata0    = data1;
          req_tag_d = cpu_tag + 1'b1;
          cnt_d     = '0;
          state_d   = ST_PREF;
        end
`endif
      end
      default: begin
        if (bus.mem_ack_i) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
`ifdef INST_FETCH_PREFETCH_EN
          if (state_q == ST_PREF) begin
            fill1 = 1'b1;
          end else begin
            fill0 = 1'b1;
            if (!flush_i) begin
              req_tag_d = req_tag_q + 1'b1;
              state_d   = ST_PREF;
            end
          end
`else
          fill0 = 1'b1;
`endif
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          // Abandon the request; IDLE re-requests next cycle if the miss persists.
          cnt_d   = '0;
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    endcase
  end

  assign bus.mem_req_o  = (state_q != ST_IDLE);
  assign bus.mem_addr_o = {req_tag_q, {ALIGN_W{1'b0}}};
  assign err_o          = err_q;

endmodule

// File: tb/tb_inst_fetch_buf.sv
// Self-checking bench for inst_fetch_buf: directed scenarios plus randomized traffic
// against a word-level model of buffer contents and bus protocol.
module tb_inst_fetch_buf;

  localparam int          AW  = 32;
  localparam int          DW  = 32;
  localparam int          TMO = 8;
  localparam logic [31:0] D0  = 32'h3401_1100;
  localparam logic [31:0] D40 = 32'hDEAD_0040;
  localparam logic [31:0] D4  = 32'hCAFE_0004;

  logic          clk = 1'b0;
  logic          rst;
  logic          cpu_ce;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_inst;
  logic          stall;
  logic          flush;
  logic          err;
  logic          req;
  logic [AW-1:0] maddr;

  int tests = 0;
  int fails = 0;

  inst_fetch_buf_if #(.ADDR_W(AW), .DATA_W(DW)) bus_if ();

  inst_fetch_buf #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TMO)) dut (
    .clk         (clk),
    .rst         (rst),
    .cpu_ce_i    (cpu_ce),
    .cpu_addr_i  (cpu_addr),
    .cpu_inst_o  (cpu_inst),
    .stall_req_o (stall),
    .flush_i     (flush),
    .bus         (bus_if),
    .err_o       (err)
  );

  assign req   = bus_if.mem_req_o;
  assign maddr = bus_if.mem_addr_o;

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
    logic [AW-1:0] w;
    w = {a[AW-1:2], 2'b00};
    return (w * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  // Acknowledge the prefetch that follows a demand fill (no-op without the feature).
  task automatic drain_prefetch();
`ifdef INST_FETCH_PREFETCH_EN
    bit done;
    done = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      if (req) begin
        bus_if.mem_ack_i   = 1'b1;
        bus_if.mem_rdata_i = mem_word(maddr);
        @(negedge clk);
        bus_if.mem_ack_i = 1'b0;
        #1;
        done = 1'b1;
      end else begin
        @(negedge clk);
        #1;
      end
    end
    tests++;
    if (!done) begin fails++; $display("FAIL drain_prefetch: no prefetch request within 20 cycles"); end
`endif
  endtask

  task automatic test_reset();
    rst = 1'b0; cpu_ce = 1'b0; cpu_addr = '0; flush = 1'b0;
    bus_if.mem_ack_i = 1'b0; bus_if.mem_rdata_i = '0;
    repeat (3) @(negedge clk);
    #1;
    tests++;
    if (cpu_inst !== 0 || stall !== 0 || req !== 0 || maddr !== 0 || err !== 0) begin
      fails++;
      $display("FAIL reset_outputs: inst=%h stall=%b req=%b addr=%h err=%b, want all zero",
               cpu_inst, stall, req, maddr, err);
    end
    @(negedge clk); rst = 1'b1;
    @(negedge clk); cpu_ce = 1'b1; cpu_addr = 32'h0; #1;
    tests++;
    if (stall !== 1'b1 || req !== 1'b0) begin
      fails++; $display("FAIL first_miss: stall=%b req=%b, want stall=1 req=0", stall, req);
    end
    @(negedge clk); #1;
    tests++;
    if (req !== 1'b1 || maddr !== 32'h0) begin
      fails++; $display("FAIL req_cycle1: req=%b addr=%h, want req=1 addr=0", req, maddr);
    end
    @(negedge clk); #1;
    @(negedge clk); bus_if.mem_ack_i = 1'b1; bus_if.mem_rdata_i = D0; #1;
    tests++;
    if (stall !== 1'b1) begin fails++; $display("FAIL stall_during_ack: stall=%b want 1", stall); end
    @(negedge clk); bus_if.mem_ack_i = 1'b0; #1;
    tests++;
    if (stall !== 1'b0 || cpu_inst !== D0) begin
      fails++; $display("FAIL fill_hit: stall=%b inst=%h, want stall=0 inst=%h", stall, cpu_inst, D0);
    end
    tests++;
`ifdef INST_FETCH_PREFETCH_EN
    if (req !== 1'b1 || maddr !== 32'h4) begin
      fails++; $display("FAIL prefetch_after_fill: req=%b addr=%h, want req=1 addr=4", req, maddr);
    end
`else
    if (req !== 1'b0) begin fails++; $display("FAIL req_after_fill: req=%b want 0", req); end
`endif
  endtask

  task automatic test_repeat_hit();
    drain_prefetch();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1;
      tests++;
      if (req !== 1'b0 || stall !== 1'b0 || cpu_inst !== D0) begin
        fails++;
        $display("FAIL repeat_hit[%0d]: req=%b stall=%b inst=%h, want 0/0/%h", i, req, stall, cpu_inst, D0);
      end
    end
  endtask

  task automatic test_timeout();
    @(negedge clk); cpu_addr = 32'h40; #1;
    tests++;
    if (stall !== 1'b1) begin fails++; $display("FAIL timeout_miss: stall=%b want 1", stall); end
    for (int i = 1; i <= TMO; i++) begin
      @(negedge clk); #1;
      tests++;
      if (req !== 1'b1 || maddr !== 32'h40 || err !== 1'b0) begin
        fails++;
        $display("FAIL timeout_busy[%0d]: req=%b addr=%h err=%b, want 1/40/0", i, req, maddr, err);
      end
    end
    @(negedge clk); #1;
    tests++;
    if (req !== 1'b0 || err !== 1'b1) begin
      fails++; $display("FAIL timeout_drop: req=%b err=%b, want req=0 err=1", req, err);
    end
    @(negedge clk); #1;
    tests++;
    if (req !== 1'b1 || maddr !== 32'h40) begin
      fails++; $display("FAIL timeout_retry: req=%b addr=%h, want req=1 addr=40", req, maddr);
    end
    bus_if.mem_ack_i = 1'b1; bus_if.mem_rdata_i = D40;
    @(negedge clk); bus_if.mem_ack_i = 1'b0; #1;
    tests++;
    if (stall !== 1'b0 || cpu_inst !== D40 || err !== 1'b1) begin
      fails++;
      $display("FAIL timeout_fill: stall=%b inst=%h err=%b, want 0/%h/1", stall, cpu_inst, err, D40);
    end
    drain_prefetch();
  endtask

  task automatic test_flush_race();
    @(negedge clk); cpu_ce = 1'b0; flush = 1'b1;
    @(negedge clk); flush = 1'b0; cpu_ce = 1'b1; cpu_addr = 32'h4; #1;
    tests++;
    if (stall !== 1'b1) begin fails++; $display("FAIL flush_miss: stall=%b want 1", stall); end
    @(negedge clk); #1;
    tests++;
    if (req !== 1'b1 || maddr !== 32'h4) begin
      fails++; $display("FAIL flush_req: req=%b addr=%h, want 1/4", req, maddr);
    end
    @(negedge clk); bus_if.mem_ack_i = 1'b1; bus_if.mem_rdata_i = D4; flush = 1'b1;
    @(negedge clk); bus_if.mem_ack_i = 1'b0; flush = 1'b0; #1;
    tests++;
    if (stall !== 1'b1 || req !== 1'b0 || cpu_inst !== 0) begin
      fails++;
      $display("FAIL flush_wins: stall=%b req=%b inst=%h, want stall=1 req=0 inst=0", stall, req, cpu_inst);
    end
    @(negedge clk); #1;
    tests++;
    if (req !== 1'b1 || maddr !== 32'h4) begin
      fails++; $display("FAIL flush_rereq: req=%b addr=%h, want 1/4", req, maddr);
    end
    bus_if.mem_ack_i = 1'b1; bus_if.mem_rdata_i = D4;
    @(negedge clk); bus_if.mem_ack_i = 1'b0; #1;
    tests++;
    if (stall !== 1'b0 || cpu_inst !== D4) begin
      fails++; $display("FAIL flush_refill: stall=%b inst=%h, want 0/%h", stall, cpu_inst, D4);
    end
    drain_prefetch();
  endtask

  task automatic test_async_reset();
    @(negedge clk); cpu_addr = 32'h80; #1;
    @(negedge clk); #1;
    tests++;
    if (req !== 1'b1 || maddr !== 32'h80) begin
      fails++; $display("FAIL arst_busy: req=%b addr=%h, want 1/80", req, maddr);
    end
    cpu_addr = 32'h4; #1;
    tests++;
    if (stall !== 1'b0 || cpu_inst !== D4) begin
      fails++; $display("FAIL arst_hit_in_busy: stall=%b inst=%h, want 0/%h", stall, cpu_inst, D4);
    end
    #1 rst = 1'b0;
    #1;
    tests++;
    if (req !== 1'b0 || cpu_inst !== 0 || stall !== 1'b1 || err !== 1'b0 || maddr !== 0) begin
      fails++;
      $display("FAIL arst_immediate: req=%b inst=%h stall=%b err=%b addr=%h, want 0/0/1/0/0",
               req, cpu_inst, stall, err, maddr);
    end
    @(negedge clk); rst = 1'b1; #1;
    tests++;
    if (stall !== 1'b1) begin fails++; $display("FAIL arst_first_miss: stall=%b want 1", stall); end
    @(negedge clk); #1;
    tests++;
    if (req !== 1'b1 || maddr !== 32'h4) begin
      fails++; $display("FAIL arst_req: req=%b addr=%h, want 1/4", req, maddr);
    end
    bus_if.mem_ack_i = 1'b1; bus_if.mem_rdata_i = D4;
    @(negedge clk); bus_if.mem_ack_i = 1'b0; #1;
    tests++;
    if (stall !== 1'b0 || cpu_inst !== D4) begin
      fails++; $display("FAIL arst_refill: stall=%b inst=%h, want 0/%h", stall, cpu_inst, D4);
    end
    drain_prefetch();
  endtask

`ifdef INST_FETCH_PREFETCH_EN
  // Serve one request at the current cycle, checking its address first.
  task automatic serve_expect(input logic [AW-1:0] a, input string name);
    tests++;
    if (req !== 1'b1 || maddr !== a) begin
      fails++; $display("FAIL %s: req=%b addr=%h, want req=1 addr=%h", name, req, maddr, a);
    end
    bus_if.mem_ack_i = 1'b1; bus_if.mem_rdata_i = mem_word(a);
    @(negedge clk); bus_if.mem_ack_i = 1'b0;
  endtask

  task automatic test_stream();
    @(negedge clk); cpu_ce = 1'b0; flush = 1'b1;
    @(negedge clk); flush = 1'b0; cpu_ce = 1'b1; cpu_addr = 32'h100;
    @(negedge clk); #1;
    serve_expect(32'h100, "stream_demand_100");
    #1;
    serve_expect(32'h104, "stream_pref_104");
    cpu_addr = 32'h104; #1;
    tests++;
    if (stall !== 1'b0 || cpu_inst !== mem_word(32'h104)) begin
      fails++;
      $display("FAIL stream_hit_104: stall=%b inst=%h, want 0/%h", stall, cpu_inst, mem_word(32'h104));
    end
    @(negedge clk); #1;
    serve_expect(32'h108, "stream_pref_108");
    cpu_addr = 32'hFFFF_FFFC;
    @(negedge clk); #1;
    serve_expect(32'hFFFF_FFFC, "stream_demand_top");
    #1;
    serve_expect(32'h0, "stream_pref_wrap");
    cpu_addr = 32'h0; #1;
    tests++;
    if (stall !== 1'b0 || cpu_inst !== mem_word(32'h0)) begin
      fails++;
      $display("FAIL stream_hit_wrap: stall=%b inst=%h, want 0/%h", stall, cpu_inst, mem_word(32'h0));
    end
    @(negedge clk); #1;
    drain_prefetch();
  endtask
`endif

  task automatic test_random();
    logic          mvalid, req_prev, ack_prev, prev_miss, exp_hit;
    logic [29:0]   mtag;
    logic [AW-1:0] prev_addr, prev_maddr;
    int            lat;
    @(negedge clk); cpu_ce = 1'b0; flush = 1'b1; bus_if.mem_ack_i = 1'b0;
    #1;
    mvalid = 1'b0; mtag = '0; lat = -1;
    req_prev = req; ack_prev = 1'b0; prev_miss = 1'b0; prev_addr = '0; prev_maddr = maddr;
    for (int c = 0; c < 800; c++) begin
      @(negedge clk);
      cpu_ce   = ($urandom_range(9) != 0);
      cpu_addr = 32'h200 + ($urandom_range(7) << 2) + $urandom_range(3);
      flush    = ($urandom_range(29) == 0);
      bus_if.mem_ack_i = 1'b0;
      if (req) begin
        if (lat < 0) lat = $urandom_range(4);
        if (lat == 0) begin
          bus_if.mem_ack_i   = 1'b1;
          bus_if.mem_rdata_i = mem_word(maddr);
          lat = -1;
        end else begin
          lat--;
        end
      end else begin
        lat = -1;
      end
      #1;
      exp_hit = cpu_ce && mvalid && (mtag == cpu_addr[31:2]);
      tests++;
      if (!cpu_ce && (stall !== 1'b0 || cpu_inst !== 0)) begin
        fails++; $display("FAIL rnd_ce_low[%0d]: stall=%b inst=%h, want 0/0", c, stall, cpu_inst);
      end
      tests++;
      if (cpu_ce && !stall && cpu_inst !== mem_word(cpu_addr)) begin
        fails++;
        $display("FAIL rnd_hit_data[%0d]: addr=%h inst=%h want %h", c, cpu_addr, cpu_inst, mem_word(cpu_addr));
      end
`ifndef INST_FETCH_PREFETCH_EN
      tests++;
      if (stall !== (cpu_ce && !exp_hit)) begin
        fails++; $display("FAIL rnd_stall[%0d]: addr=%h stall=%b want %b", c, cpu_addr, stall, cpu_ce && !exp_hit);
      end
      tests++;
      if (!req_prev && (req !== prev_miss || (req && maddr !== {prev_addr[31:2], 2'b00}))) begin
        fails++;
        $display("FAIL rnd_req_issue[%0d]: req=%b addr=%h want req=%b addr=%h",
                 c, req, maddr, prev_miss, {prev_addr[31:2], 2'b00});
      end
      tests++;
      if (req_prev && !ack_prev && (req !== 1'b1 || maddr !== prev_maddr)) begin
        fails++; $display("FAIL rnd_req_hold[%0d]: req=%b addr=%h want 1/%h", c, req, maddr, prev_maddr);
      end
      tests++;
      if (req_prev && ack_prev && req !== 1'b0) begin
        fails++; $display("FAIL rnd_req_release[%0d]: req=%b want 0", c, req);
      end
`endif
      if (flush) begin
        mvalid = 1'b0;
      end else if (bus_if.mem_ack_i) begin
        mvalid = 1'b1;
        mtag   = maddr[31:2];
      end
      req_prev = req; ack_prev = bus_if.mem_ack_i; prev_miss = cpu_ce && !exp_hit;
      prev_addr = cpu_addr; prev_maddr = maddr;
    end
    @(negedge clk); flush = 1'b0; bus_if.mem_ack_i = 1'b0; #1;
    tests++;
    if (err !== 1'b0) begin fails++; $display("FAIL rnd_no_timeout: err=%b want 0", err); end
  endtask

  initial begin
    test_reset();
    test_repeat_hit();
    test_timeout();
    test_flush_race();
    test_async_reset();
`ifdef INST_FETCH_PREFETCH_EN
    test_stream();
`endif
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d tests run", tests);
    $fatal(1, "watchdog expired");
  end

endmodule
